// File: rtl/seg_pkg.sv
// Shared constants, FSM state type and helpers for the 7-segment capture block.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_HOLD
    } state_e;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'h0) && ((v & (v - 4'h1)) == 4'h0);
    endfunction

endpackage

// File: rtl/seg_to_nibble.sv
// Inverse hex-table lookup: active-low segment pattern to nibble.
module seg_to_nibble
    import seg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] nibble_o,
    output logic       valid_o
);

    always_comb begin
        nibble_o = 4'h0;
        valid_o  = 1'b1;
        case (pattern_i)
            SEG_0:   nibble_o = 4'h0;
            SEG_1:   nibble_o = 4'h1;
            SEG_2:   nibble_o = 4'h2;
            SEG_3:   nibble_o = 4'h3;
            SEG_4:   nibble_o = 4'h4;
            SEG_5:   nibble_o = 4'h5;
            SEG_6:   nibble_o = 4'h6;
            SEG_7:   nibble_o = 4'h7;
            SEG_8:   nibble_o = 4'h8;
            SEG_9:   nibble_o = 4'h9;
            SEG_A:   nibble_o = 4'hA;
            SEG_B:   nibble_o = 4'hB;
            SEG_C:   nibble_o = 4'hC;
            SEG_D:   nibble_o = 4'hD;
            SEG_E:   nibble_o = 4'hE;
            SEG_F:   nibble_o = 4'hF;
            default: valid_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/hex_seg_capture.sv
// Debounced capture of a multiplexed 4-digit 7-segment display into a 16-bit word.
// Define SEG_ERR_COUNT_EN to add the saturating err_count output.
module hex_seg_capture
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  dig_sel,
    output logic [15:0] data_out,
    output logic        data_valid,
`ifdef SEG_ERR_COUNT_EN
    output logic [7:0]  err_count,
`endif
    output logic        pattern_err
);

    localparam logic [7:0] STABLE_L = 8'(STABLE_CYCLES);
    localparam logic [10:0] IDLE_SMP = {4'h0, SEG_BLANK};

    state_e      state_q, state_d;
    logic [6:0]  seg_q;
    logic [3:0]  sel_q;
    logic [10:0] prev_q;
    logic [10:0] held_q, held_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] slots_q, slots_d;
    logic [15:0] dout_q, dout_d;
    logic        valid_q, valid_d;
    logic        perr_q, perr_d;

    logic [10:0] cur;
    logic        accept;
    logic [3:0]  acc_sel;
    logic [3:0]  nib;
    logic        nib_ok;

    assign cur     = {sel_q, seg_q};
    assign acc_sel = prev_q[10:7];

    // The accepted sample is the last one counted, which now sits in prev_q.
    seg_to_nibble u_dec (
        .pattern_i (prev_q[6:0]),
        .nibble_o  (nib),
        .valid_o   (nib_ok)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        held_d  = held_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_WAIT: begin
                if (is_onehot4(sel_q)) begin
                    cnt_d   = 8'd1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == STABLE_L) begin
                    accept  = 1'b1;
                    held_d  = prev_q;
                    state_d = ST_HOLD;
                end else if (cur == prev_q) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (is_onehot4(sel_q)) begin
                    cnt_d = 8'd1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (cur != held_q) state_d = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_comb begin
        slots_d = slots_q;
        mask_d  = mask_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        if (mask_q == 4'hF) begin
            dout_d  = slots_q;
            valid_d = 1'b1;
            mask_d  = 4'h0;
        end
        if (accept) begin
            if (nib_ok) begin
                for (int i = 0; i < 4; i++) begin
                    if (acc_sel[i]) slots_d[i*4 +: 4] = nib;
                end
                mask_d = mask_d | acc_sel;
            end else begin
                perr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q   <= SEG_BLANK;
            sel_q   <= 4'h0;
            prev_q  <= IDLE_SMP;
            held_q  <= IDLE_SMP;
            state_q <= ST_WAIT;
            cnt_q   <= 8'd0;
            mask_q  <= 4'h0;
            slots_q <= 16'h0000;
            dout_q  <= 16'h0000;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            seg_q   <= seg_in;
            sel_q   <= dig_sel;
            prev_q  <= cur;
            held_q  <= held_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            slots_q <= slots_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
        end
    end

`ifdef SEG_ERR_COUNT_EN
    logic [7:0] errc_q, errc_d;

    always_comb begin
        errc_d = errc_q;
        if (accept && !nib_ok && errc_q != 8'hFF) errc_d = errc_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) errc_q <= 8'd0;
        else     errc_q <= errc_d;
    end

    assign err_count = errc_q;
`endif

    assign data_out    = dout_q;
    assign data_valid  = valid_q;
    assign pattern_err = perr_q;

endmodule
